// File: rtl/fft_frame_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_pingpong_buf
// Description : Double-buffered (ping-pong) frame store for FFT magnitudes.
//               One bank fills with the incoming spectrum frame while the
//               display reader scans the other. Banks swap on frame
//               completion whenever the reader is not locked. An optional
//               peak-hold mode stores max(new, held) per bin, and a clear
//               sequencer zeroes the peak store one bin per cycle.
// Ports       : clk, rst_n                      clock / async active-low reset
//               in_valid, in_ready, in_data,
//               in_last, peak_en                 input bin stream
//               peak_clr, clr_busy               peak store clear control
//               rd_lock, rd_en, rd_addr, rd_data display read port
//               frame_vld, frame_rdy,
//               frame_len, frame_cnt             frame status
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_pingpong_buf #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              peak_en,
    input  logic              peak_clr,
    output logic              clr_busy,
    input  logic              rd_lock,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_vld,
    output logic              frame_rdy,
    output logic [ADDR_W:0]   frame_len,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int              c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_ptr_max = {ADDR_W{1'b1}};
    localparam logic [0:0]      c_st_fill  = 1'b0;
    localparam logic [0:0]      c_st_hold  = 1'b1;

    logic [0:0]        r_state;
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_len_q;
    logic              r_clr_busy;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_frame_vld;
    logic              r_frame_rdy;
    logic [ADDR_W:0]   r_frame_len;
    logic [CNT_W-1:0]  r_frame_cnt;

    // Both banks share one array; the bank select is the address MSB.
    logic [DATA_W-1:0] r_bank_mem [0:2*c_depth-1];
    logic [DATA_W-1:0] r_peak_mem [0:c_depth-1];

    logic              w_in_ready;
    logic              w_accept;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_peak_old;
    logic [DATA_W-1:0] w_wr_val;

    // Input is stalled both while a finished frame waits to swap and while
    // the peak store is being cleared, so beats never race the clear.
    assign w_in_ready  = (r_state == c_st_fill) && !r_clr_busy;
    assign w_accept    = in_valid && w_in_ready;
    assign w_frame_end = in_last || (r_wr_ptr == c_ptr_max);
    assign w_peak_old  = r_peak_mem[r_wr_ptr];
    assign w_wr_val    = (peak_en && (w_peak_old > in_data)) ? w_peak_old : in_data;

    // Write FSM, frame status, clear sequencer and read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_fill;
            r_wr_bank   <= 1'b0;
            r_wr_ptr    <= '0;
            r_len_q     <= '0;
            r_clr_busy  <= 1'b0;
            r_clr_cnt   <= '0;
            r_rd_data   <= '0;
            r_frame_vld <= 1'b0;
            r_frame_rdy <= 1'b0;
            r_frame_len <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_frame_rdy <= 1'b0;

            case (r_state)
                c_st_fill: begin
                    if (w_accept) begin
                        if (w_frame_end) begin
                            r_len_q  <= {1'b0, r_wr_ptr} + (ADDR_W+1)'(1);
                            r_wr_ptr <= '0;
                            r_state  <= c_st_hold;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                c_st_hold: begin
                    // Frames are never dropped: wait here until the reader
                    // releases its lock, then swap.
                    if (!rd_lock) begin
                        r_wr_bank   <= ~r_wr_bank;
                        r_frame_len <= r_len_q;
                        r_frame_vld <= 1'b1;
                        r_frame_rdy <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_state     <= c_st_fill;
                    end
                end
                default: r_state <= c_st_fill;
            endcase

            // A new request always restarts the sweep from bin 0.
            if (peak_clr) begin
                r_clr_busy <= 1'b1;
                r_clr_cnt  <= '0;
            end else if (r_clr_busy) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_ptr_max) begin
                    r_clr_busy <= 1'b0;
                end
            end

            // Display bank is the one not being filled; on the swap edge the
            // old display bank is still selected.
            if (rd_en) begin
                r_rd_data <= r_bank_mem[{~r_wr_bank, rd_addr}];
            end
        end
    end

    // Storage arrays are not reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_bank_mem[{r_wr_bank, r_wr_ptr}] <= w_wr_val;
        end
        if (r_clr_busy) begin
            r_peak_mem[r_clr_cnt] <= '0;
        end else if (w_accept && peak_en) begin
            r_peak_mem[r_wr_ptr] <= w_wr_val;
        end
    end

    assign in_ready  = w_in_ready;
    assign clr_busy  = r_clr_busy;
    assign rd_data   = r_rd_data;
    assign frame_vld = r_frame_vld;
    assign frame_rdy = r_frame_rdy;
    assign frame_len = r_frame_len;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_pingpong_buf
// Description : Self-checking bench for fft_frame_pingpong_buf. Random frame
//               data is pushed through the DUT and compared against a
//               bank/peak array model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_pingpong_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        in_last;
    logic        peak_en;
    logic        peak_clr;
    logic        clr_busy;
    logic        rd_lock;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data;
    logic        frame_vld;
    logic        frame_rdy;
    logic [8:0]  frame_len;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: two banks of 256 bins, the peak store, which bank is
    // filling, and the frame status the display side should see.
    logic [11:0] ref_mem  [0:511];
    logic [11:0] ref_peak [0:255];
    int          ref_wbank;
    int          ref_cnt;
    logic [11:0] fdata [0:255];

    fft_frame_pingpong_buf #(.DATA_W(12), .ADDR_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .peak_en   (peak_en),
        .peak_clr  (peak_clr),
        .clr_busy  (clr_busy),
        .rd_lock   (rd_lock),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .frame_vld (frame_vld),
        .frame_rdy (frame_rdy),
        .frame_len (frame_len),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_frame();
        for (int i = 0; i < 256; i++) fdata[i] = 12'($urandom_range(4095));
    endtask

    // Stream bins lo..hi with random gaps; in_last on hi when last_flag.
    task automatic send_beats(input int lo, input int hi, input bit last_flag, input bit pk);
        int wait_n;
        logic [11:0] v;
        for (int i = lo; i <= hi; i++) begin
            if ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = fdata[i];
            in_last  = last_flag && (i == hi);
            peak_en  = pk;
            wait_n   = 0;
            while (!in_ready && wait_n < 2000) begin
                step();
                wait_n++;
            end
            checks++;
            if (wait_n >= 2000) begin
                errors++;
                $display("FAIL beat_timeout: in_ready stuck at %0b, required 1 (bin %0d)", in_ready, i);
            end
            step();
            v = (pk && ref_peak[i] > fdata[i]) ? ref_peak[i] : fdata[i];
            ref_mem[ref_wbank*256 + i] = v;
            if (pk) ref_peak[i] = v;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        peak_en  = 1'b0;
    endtask

    // Called right after the completing beat with rd_lock low.
    task automatic finish_frame(input int n);
        checks++;
        if (in_ready !== 1'b0 || frame_rdy !== 1'b0) begin
            errors++;
            $display("FAIL hold_entry: in_ready=%0b frame_rdy=%0b, required 0 0", in_ready, frame_rdy);
        end
        step();
        ref_wbank = 1 - ref_wbank;
        ref_cnt++;
        checks++;
        if (frame_rdy !== 1'b1 || frame_vld !== 1'b1 || frame_len !== 9'(n) || frame_cnt !== 16'(ref_cnt)) begin
            errors++;
            $display("FAIL swap: rdy=%0b vld=%0b len=%0d cnt=%0d, required 1 1 %0d %0d",
                     frame_rdy, frame_vld, frame_len, frame_cnt, n, ref_cnt);
        end
        step();
        checks++;
        if (frame_rdy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_swap: frame_rdy=%0b in_ready=%0b, required 0 1", frame_rdy, in_ready);
        end
    endtask

    task automatic read_bank(input int n);
        int disp;
        int a;
        disp = 1 - ref_wbank;
        for (a = 0; a < n; a++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(a);
            step();
            checks++;
            if (rd_data !== ref_mem[disp*256 + a]) begin
                errors++;
                $display("FAIL read[%0d]: got %0d, required %0d", a, rd_data, ref_mem[disp*256 + a]);
            end
        end
        rd_en   = 1'b0;
        rd_addr = 8'($urandom_range(255));
        step();
        checks++;
        if (rd_data !== ref_mem[disp*256 + n - 1]) begin
            errors++;
            $display("FAIL read_hold: got %0d, required %0d", rd_data, ref_mem[disp*256 + n - 1]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b1 || clr_busy !== 1'b0 || rd_data !== 12'd0 || frame_vld !== 1'b0 ||
            frame_rdy !== 1'b0 || frame_len !== 9'd0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s: rdy=%0b busy=%0b rd=%0d vld=%0b frdy=%0b len=%0d cnt=%0d, required 1 0 0 0 0 0 0",
                     tag, in_ready, clr_busy, rd_data, frame_vld, frame_rdy, frame_len, frame_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        step();
        check_reset_outputs("after_reset_release");
        ref_wbank = 0;
        ref_cnt   = 0;
    endtask

    task automatic test_full_frame();
        gen_frame();
        send_beats(0, 255, 1'b1, 1'b0);
        finish_frame(256);
        read_bank(256);
    endtask

    task automatic test_lock();
        int a;
        logic [11:0] exp_old;
        gen_frame();
        rd_lock = 1'b1;
        send_beats(0, 255, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            a       = $urandom_range(255);
            rd_en   = 1'b1;
            rd_addr = 8'(a);
            step();
            checks++;
            if (in_ready !== 1'b0 || frame_rdy !== 1'b0 || frame_cnt !== 16'(ref_cnt) ||
                rd_data !== ref_mem[(1-ref_wbank)*256 + a]) begin
                errors++;
                $display("FAIL locked_hold: in_ready=%0b frame_rdy=%0b cnt=%0d rd=%0d, required 0 0 %0d %0d",
                         in_ready, frame_rdy, frame_cnt, rd_data, ref_cnt, ref_mem[(1-ref_wbank)*256 + a]);
            end
        end
        a       = $urandom_range(255);
        rd_addr = 8'(a);
        exp_old = ref_mem[(1-ref_wbank)*256 + a];
        rd_lock = 1'b0;
        step();
        ref_wbank = 1 - ref_wbank;
        ref_cnt++;
        checks++;
        if (frame_rdy !== 1'b1 || frame_cnt !== 16'(ref_cnt) || rd_data !== exp_old) begin
            errors++;
            $display("FAIL unlock_swap: frame_rdy=%0b cnt=%0d rd=%0d, required 1 %0d %0d",
                     frame_rdy, frame_cnt, rd_data, ref_cnt, exp_old);
        end
        step();
        checks++;
        if (frame_rdy !== 1'b0 || rd_data !== ref_mem[(1-ref_wbank)*256 + a]) begin
            errors++;
            $display("FAIL post_swap_read: frame_rdy=%0b rd=%0d, required 0 %0d",
                     frame_rdy, rd_data, ref_mem[(1-ref_wbank)*256 + a]);
        end
        rd_en = 1'b0;
        read_bank(256);
    endtask

    task automatic test_short_frame();
        gen_frame();
        send_beats(0, 99, 1'b1, 1'b0);
        finish_frame(100);
        read_bank(100);
        gen_frame();
        send_beats(0, 255, 1'b1, 1'b0);
        finish_frame(256);
        read_bank(256);
    endtask

    task automatic test_peak();
        int n;
        logic [11:0] b5 [0:3];
        logic [11:0] exp5 [0:3];
        b5[0] = 12'd300;  exp5[0] = 12'd300;
        b5[1] = 12'd120;  exp5[1] = 12'd300;
        b5[2] = 12'd4095; exp5[2] = 12'd4095;
        b5[3] = 12'd7;    exp5[3] = 12'd7;
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        n = 0;
        while (clr_busy && n < 1000) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL clr_ready: in_ready=%0b during clear, required 0", in_ready);
            end
            n++;
            step();
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL clr_busy_len: busy for %0d cycles, required 256", n);
        end
        for (int i = 0; i < 256; i++) ref_peak[i] = 12'd0;
        for (int f = 0; f < 4; f++) begin
            gen_frame();
            fdata[5] = b5[f];
            // Last frame runs to the bank end without in_last.
            send_beats(0, 255, f != 3, f != 3);
            finish_frame(256);
            read_bank(256);
            rd_en   = 1'b1;
            rd_addr = 8'd5;
            step();
            rd_en = 1'b0;
            checks++;
            if (rd_data !== exp5[f]) begin
                errors++;
                $display("FAIL peak_bin5[%0d]: got %0d, required %0d", f, rd_data, exp5[f]);
            end
        end
    endtask

    task automatic test_clr_midframe();
        int n;
        gen_frame();
        send_beats(0, 39, 1'b0, 1'b0);
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        n = 0;
        while (!in_ready && n < 1000) begin
            n++;
            step();
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL midframe_stall: in_ready low %0d cycles, required 256", n);
        end
        for (int i = 0; i < 256; i++) ref_peak[i] = 12'd0;
        send_beats(40, 255, 1'b1, 1'b0);
        finish_frame(256);
        read_bank(256);
    endtask

    task automatic test_reset_midframe();
        gen_frame();
        send_beats(0, 49, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        rst_n     = 1'b1;
        ref_wbank = 0;
        ref_cnt   = 0;
        step();
        gen_frame();
        send_beats(0, 255, 1'b1, 1'b0);
        finish_frame(256);
        read_bank(256);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        peak_en  = 1'b0;
        peak_clr = 1'b0;
        rd_lock  = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        ref_wbank = 0;
        ref_cnt   = 0;
        test_reset();
        test_full_frame();
        test_lock();
        test_short_frame();
        test_peak();
        test_clr_midframe();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
